// File: rtl/approx_mult_err_monitor.sv
// approx_mult_err_monitor
//   Error-statistics stage for the 8x8 approximate recursive multipliers.
//   It accepts (a, b, y) samples, recomputes the exact product a*b, and over a
//   run of N_SAMPLES accepted samples accumulates the error count, the
//   saturating sum of absolute errors and the worst error with its operands.
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           1-cycle pulse: clears stats and begins a run (IDLE/DONE only)
//   in_valid        sample valid
//   in_ready        high while the monitor is in RUN
//   in_a, in_b      operands
//   in_y            approximate product under test
//   busy            RUN or DRAIN
//   done            DONE, held until the next start
//   sample_count    samples accepted this run
//   err_count       samples whose product was wrong
//   err_sum         saturating sum of |in_y - in_a*in_b|
//   max_err         largest absolute error seen
//   max_err_a/b     operands of the first sample that reached max_err
module approx_mult_err_monitor #(
  parameter int unsigned W         = 8,
  parameter int unsigned N_SAMPLES = 65536,
  parameter int unsigned CNT_W     = 17,
  parameter int unsigned SUM_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic [2*W-1:0]     in_y,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_count,
  output logic [CNT_W-1:0]   err_count,
  output logic [SUM_W-1:0]   err_sum,
  output logic [2*W-1:0]     max_err,
  output logic [W-1:0]       max_err_a,
  output logic [W-1:0]       max_err_b
);

  localparam int unsigned PW    = 2 * W;
  // Accumulator is wide enough to hold err_sum + d without wrapping
  localparam int unsigned ACC_W = ((SUM_W > PW) ? SUM_W : PW) + 1;

  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(N_SAMPLES - 1);
  localparam logic [ACC_W-1:0] SUM_MAX   = ACC_W'({SUM_W{1'b1}});
  localparam logic [1:0]       DRAIN_END = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;

  logic       accept;
  logic       start_run;

  // Stage 1: captured sample and exact product
  logic           s1_valid;
  logic [W-1:0]   s1_a, s1_b;
  logic [PW-1:0]  s1_y, s1_exact;

  // Stage 2: absolute error
  logic           s2_valid;
  logic [W-1:0]   s2_a, s2_b;
  logic [PW-1:0]  s2_d;

  logic [ACC_W-1:0] sum_ext;
  logic [SUM_W-1:0] sum_sat;

  assign accept    = in_valid && (state_q == RUN);
  assign start_run = start && ((state_q == IDLE) || (state_q == DONE));

  // Status decoded straight from the state register
  assign in_ready = (state_q == RUN);
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state logic; DRAIN lasts until the last sample has reached the stats
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept && (sample_count == LAST_IDX)) begin
          state_d     = DRAIN;
          drain_cnt_d = 2'd0;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_END) begin
          state_d = DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1 capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_y     <= '0;
      s1_exact <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_y     <= in_y;
        s1_exact <= PW'(in_a) * PW'(in_b);
      end
    end
  end

  // Stage 2 absolute difference, ordered so it never goes negative
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_a     <= '0;
      s2_b     <= '0;
      s2_d     <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_a <= s1_a;
        s2_b <= s1_b;
        s2_d <= (s1_y >= s1_exact) ? (s1_y - s1_exact) : (s1_exact - s1_y);
      end
    end
  end

  // Saturating add; once at the ceiling it stays there
  always_comb begin
    sum_ext = ACC_W'(err_sum) + ACC_W'(s2_d);
    sum_sat = (sum_ext > SUM_MAX) ? SUM_W'(SUM_MAX) : SUM_W'(sum_ext);
  end

  // Sample counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_count <= '0;
    end else if (start_run) begin
      sample_count <= '0;
    end else if (accept) begin
      sample_count <= sample_count + CNT_W'(1);
    end
  end

  // Stage 3 statistics; strict compare keeps the earliest worst sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      err_sum   <= '0;
      max_err   <= '0;
      max_err_a <= '0;
      max_err_b <= '0;
    end else if (start_run) begin
      err_count <= '0;
      err_sum   <= '0;
      max_err   <= '0;
      max_err_a <= '0;
      max_err_b <= '0;
    end else if (s2_valid) begin
      if (s2_d != '0) begin
        err_count <= err_count + CNT_W'(1);
      end
      err_sum <= sum_sat;
      if (s2_d > max_err) begin
        max_err   <= s2_d;
        max_err_a <= s2_a;
        max_err_b <= s2_b;
      end
    end
  end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Directed bench for approx_mult_err_monitor. Four instances with different
// run lengths / sum widths share the sample bus; sel picks the active one.
module tb_approx_mult_err_monitor;

  logic        clk;
  logic        rst;
  logic [3:0]  start_v;
  logic        in_valid;
  logic [7:0]  in_a, in_b;
  logic [15:0] in_y;
  int          sel;

  logic        rdy_v [4];
  logic        busy_v[4];
  logic        done_v[4];
  logic [16:0] scnt_v[4];
  logic [16:0] ecnt_v[4];
  logic [15:0] merr_v[4];
  logic [7:0]  ma_v  [4];
  logic [7:0]  mb_v  [4];
  logic [31:0] esum_v[4];
  logic [7:0]  esum_sat;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: N=4, 1: N=2, 2: N=2 with 8-bit sum, 3: N=4096 sweep
  approx_mult_err_monitor #(.N_SAMPLES(4)) u_n4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid), .in_ready(rdy_v[0]),
    .in_a(in_a), .in_b(in_b), .in_y(in_y), .busy(busy_v[0]), .done(done_v[0]),
    .sample_count(scnt_v[0]), .err_count(ecnt_v[0]), .err_sum(esum_v[0]),
    .max_err(merr_v[0]), .max_err_a(ma_v[0]), .max_err_b(mb_v[0]));

  approx_mult_err_monitor #(.N_SAMPLES(2)) u_n2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid), .in_ready(rdy_v[1]),
    .in_a(in_a), .in_b(in_b), .in_y(in_y), .busy(busy_v[1]), .done(done_v[1]),
    .sample_count(scnt_v[1]), .err_count(ecnt_v[1]), .err_sum(esum_v[1]),
    .max_err(merr_v[1]), .max_err_a(ma_v[1]), .max_err_b(mb_v[1]));

  approx_mult_err_monitor #(.N_SAMPLES(2), .SUM_W(8)) u_sat (
    .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid), .in_ready(rdy_v[2]),
    .in_a(in_a), .in_b(in_b), .in_y(in_y), .busy(busy_v[2]), .done(done_v[2]),
    .sample_count(scnt_v[2]), .err_count(ecnt_v[2]), .err_sum(esum_sat),
    .max_err(merr_v[2]), .max_err_a(ma_v[2]), .max_err_b(mb_v[2]));

  approx_mult_err_monitor #(.N_SAMPLES(4096)) u_big (
    .clk(clk), .rst(rst), .start(start_v[3]), .in_valid(in_valid), .in_ready(rdy_v[3]),
    .in_a(in_a), .in_b(in_b), .in_y(in_y), .busy(busy_v[3]), .done(done_v[3]),
    .sample_count(scnt_v[3]), .err_count(ecnt_v[3]), .err_sum(esum_v[3]),
    .max_err(merr_v[3]), .max_err_a(ma_v[3]), .max_err_b(mb_v[3]));

  assign esum_v[2] = 32'(esum_sat);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Recursive 8x8 product from four 4x4 partials; approx drops the two LSBs of the low quadrant
  function automatic logic [15:0] rec_mult(input logic [7:0] a, input logic [7:0] b, input bit approx);
    int ah, al, bh, bl, ll;
    ah = int'(a[7:4]);
    al = int'(a[3:0]);
    bh = int'(b[7:4]);
    bl = int'(b[3:0]);
    ll = al * bl;
    if (approx) ll = ll - (ll % 4);
    return 16'(((ah * bh) << 8) + ((ah * bl + al * bh) << 4) + ll);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] y);
    int n;
    n        = 0;
    in_a     = a;
    in_b     = b;
    in_y     = y;
    in_valid = 1'b1;
    while (!rdy_v[sel] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_v[sel]) begin
      check("handshake_timeout", 64'(rdy_v[sel]), 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input int idx);
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done_v[sel] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done_rise", 64'(done_v[sel]), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] iv;
    logic [7:0]  ta, tb;
    logic [15:0] ty;
    int          ex, dd, exp_cnt, exp_sum, exp_max;
    logic [7:0]  exp_ma, exp_mb;

    rst      = 1'b1;
    start_v  = 4'b0;
    in_valid = 1'b0;
    in_a     = 8'd0;
    in_b     = 8'd0;
    in_y     = 16'd0;
    sel      = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy_v[0]), 64'd0);
    check("rst_ready", 64'(rdy_v[0]), 64'd0);
    check("rst_esum_sat", 64'(esum_sat), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Async reset with samples in flight
    pulse_start(0);
    check("run_busy", 64'(busy_v[0]), 64'd1);
    check("run_ready", 64'(rdy_v[0]), 64'd1);
    send(8'd1, 8'd1, 16'd5);
    send(8'd2, 8'd2, 16'd0);
    @(negedge clk);
    check("pre_rst_errcnt", 64'(ecnt_v[0]), 64'd1);
    check("pre_rst_scnt", 64'(scnt_v[0]), 64'd2);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy_v[0]), 64'd0);
    check("arst_ready", 64'(rdy_v[0]), 64'd0);
    check("arst_done", 64'(done_v[0]), 64'd0);
    check("arst_scnt", 64'(scnt_v[0]), 64'd0);
    check("arst_errcnt", 64'(ecnt_v[0]), 64'd0);
    check("arst_esum", 64'(esum_v[0]), 64'd0);
    check("arst_maxerr", 64'(merr_v[0]), 64'd0);
    check("arst_max_a", 64'(ma_v[0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_errcnt", 64'(ecnt_v[0]), 64'd0);

    // Exact run, N=4
    pulse_start(0);
    send(8'd3, 8'd5, 16'd15);
    send(8'd255, 8'd255, 16'd65025);
    send(8'd0, 8'd7, 16'd0);
    send(8'd16, 8'd16, 16'd256);
    check("ex_scnt", 64'(scnt_v[0]), 64'd4);
    check("ex_done_t1", 64'(done_v[0]), 64'd0);
    check("ex_busy_drain", 64'(busy_v[0]), 64'd1);
    check("ex_ready_drain", 64'(rdy_v[0]), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check("ex_done_t2", 64'(done_v[0]), 64'd0);
    check("ex_errcnt", 64'(ecnt_v[0]), 64'd0);
    check("ex_esum", 64'(esum_v[0]), 64'd0);
    check("ex_maxerr", 64'(merr_v[0]), 64'd0);
    @(negedge clk);
    check("ex_done_t3", 64'(done_v[0]), 64'd1);
    check("ex_busy_done", 64'(busy_v[0]), 64'd0);

    // Handshake gaps, start during RUN, tie on max_err
    pulse_start(0);
    check("gap_scnt_clear", 64'(scnt_v[0]), 64'd0);
    check("gap_done_clear", 64'(done_v[0]), 64'd0);
    send(8'd1, 8'd2, 16'd2);
    in_a = 8'd9; in_b = 8'd9; in_y = 16'd0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    check("gap_scnt_1", 64'(scnt_v[0]), 64'd1);
    send(8'd3, 8'd3, 16'd10);
    in_a = 8'd200; in_y = 16'd7;
    @(negedge clk);
    send(8'd4, 8'd4, 16'd16);
    @(negedge clk);
    send(8'd2, 8'd3, 16'd5);
    wait_done();
    check("gap_scnt", 64'(scnt_v[0]), 64'd4);
    check("gap_errcnt", 64'(ecnt_v[0]), 64'd2);
    check("gap_esum", 64'(esum_v[0]), 64'd2);
    check("gap_maxerr", 64'(merr_v[0]), 64'd1);
    check("gap_max_a", 64'(ma_v[0]), 64'd3);
    check("gap_max_b", 64'(mb_v[0]), 64'd3);

    // Single error, N=2
    sel = 1;
    pulse_start(1);
    send(8'd15, 8'd15, 16'd193);
    send(8'd2, 8'd2, 16'd4);
    wait_done();
    check("one_errcnt", 64'(ecnt_v[1]), 64'd1);
    check("one_esum", 64'(esum_v[1]), 64'd32);
    check("one_maxerr", 64'(merr_v[1]), 64'd32);
    check("one_max_a", 64'(ma_v[1]), 64'd15);
    check("one_max_b", 64'(mb_v[1]), 64'd15);
    check("n4_hold_errcnt", 64'(ecnt_v[0]), 64'd2);

    // Saturation, 8-bit sum
    sel = 2;
    pulse_start(2);
    send(8'd20, 8'd10, 16'd0);
    send(8'd20, 8'd10, 16'd400);
    wait_done();
    check("sat_esum", 64'(esum_sat), 64'd255);
    check("sat_errcnt", 64'(ecnt_v[2]), 64'd2);
    check("sat_maxerr", 64'(merr_v[2]), 64'd200);
    check("sat_max_a", 64'(ma_v[2]), 64'd20);
    check("sat_max_b", 64'(mb_v[2]), 64'd10);

    // Sweep with exact recursive multiplier, then the approximate variant
    sel = 3;
    for (int pass = 0; pass < 2; pass++) begin
      exp_cnt = 0; exp_sum = 0; exp_max = 0; exp_ma = 8'd0; exp_mb = 8'd0;
      pulse_start(3);
      check("sw_scnt_clear", 64'(scnt_v[3]), 64'd0);
      for (int i = 0; i < 4096; i++) begin
        iv = 12'(i);
        ta = iv[7:0];
        tb = {iv[11:8], iv[11:8] ^ 4'h5};
        ty = rec_mult(ta, tb, pass == 1);
        ex = int'(ta) * int'(tb);
        dd = int'(ty) - ex;
        if (dd < 0) dd = -dd;
        if (dd != 0) exp_cnt++;
        exp_sum += dd;
        if (dd > exp_max) begin
          exp_max = dd; exp_ma = ta; exp_mb = tb;
        end
        send(ta, tb, ty);
      end
      wait_done();
      check("sw_scnt", 64'(scnt_v[3]), 64'd4096);
      check("sw_errcnt", 64'(ecnt_v[3]), 64'(exp_cnt));
      check("sw_esum", 64'(esum_v[3]), 64'(exp_sum));
      check("sw_maxerr", 64'(merr_v[3]), 64'(exp_max));
      check("sw_max_a", 64'(ma_v[3]), 64'(exp_ma));
      check("sw_max_b", 64'(mb_v[3]), 64'(exp_mb));
    end
    check("sw_approx_has_errors", 64'(ecnt_v[3] != 17'd0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
